// File: rtl/dvi_pkg.sv
// Shared DVI/VGA definitions: monitor FSM states, 640x480@60 timing and the RGB444 pixel type.
package dvi_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } mon_state_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_TOTAL  = 525;

  localparam int COORD_W = 10;
  localparam int HCNT_W  = 12;
  localparam int LIT_W   = 19;
  localparam int SUM_W   = 16;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic logic [5:0] rgb_sum(input rgb444_t p);
    return {2'b00, p.r} + {2'b00, p.g} + {2'b00, p.b};
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Polarity-normalises one raw video control pin and flags its assert/deassert edges.
module sync_edge_detect #(
  parameter bit invert_p = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic level_d;
  logic level_q;

  always_comb begin
    level_d = sig_i ^ invert_p;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_d;
  assign rise_o  = level_d & ~level_q;
  assign fall_o  = ~level_d & level_q;

endmodule

// File: rtl/dvi_stream_monitor.sv
// Receive-side DVI monitor: recovers pixel coordinates, checks line/frame timing,
// and publishes per-frame lit-pixel count and colour sum.
module dvi_stream_monitor
  import dvi_pkg::*;
#(
  parameter int h_active_p        = VGA_H_ACTIVE,
  parameter int v_active_p        = VGA_V_ACTIVE,
  parameter int h_total_p         = VGA_H_TOTAL,
  parameter int sync_active_low_p = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic                de_i,
  input  logic [3:0]          r_i,
  input  logic [3:0]          g_i,
  input  logic [3:0]          b_i,
  output logic                pixel_valid_o,
  output logic [COORD_W-1:0]  sx_o,
  output logic [COORD_W-1:0]  sy_o,
  output logic [11:0]         rgb_o,
  output logic                locked_o,
  output logic                frame_done_o,
  output logic [LIT_W-1:0]    lit_count_o,
  output logic [SUM_W-1:0]    color_sum_o,
  output logic                err_o
);

  localparam logic [1:0] ST_SEARCH = SEARCH;
  localparam logic [1:0] ST_ALIGN  = ALIGN;
  localparam logic [1:0] ST_LOCKED = LOCKED;

  // Index 0: hsync, 1: vsync, 2: de. Only the syncs carry pin polarity.
  logic [2:0] raw_sig;
  logic [2:0] lvl_sig;
  logic [2:0] rise_sig;
  logic [2:0] fall_sig;

  assign raw_sig = {de_i, vsync_i, hsync_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    localparam bit INV = (gi < 2) && (sync_active_low_p != 0);
    sync_edge_detect #(
      .invert_p (INV)
    ) u_edge (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .sig_i   (raw_sig[gi]),
      .level_o (lvl_sig[gi]),
      .rise_o  (rise_sig[gi]),
      .fall_o  (fall_sig[gi])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{lvl_sig[1:0], fall_sig[1:0], rise_sig[2]};

  logic hs_rise;
  logic vs_rise;
  logic de_lvl;
  logic de_rise;
  logic de_fall;

  assign hs_rise = rise_sig[0];
  assign vs_rise = rise_sig[1];
  assign de_lvl  = lvl_sig[2];
  assign de_rise = rise_sig[2];
  assign de_fall = fall_sig[2];

  logic [1:0]         state_q, state_d;
  logic               align_err_q, align_err_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic [COORD_W-1:0] sx_q, sx_d;
  logic [COORD_W-1:0] sy_q, sy_d;
  logic [11:0]        rgb_q, rgb_d;
  logic [HCNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic               h_seen_q, h_seen_d;
  logic               locked_q, locked_d;
  logic               frame_done_q, frame_done_d;
  logic [LIT_W-1:0]   lit_acc_q, lit_acc_d;
  logic [SUM_W-1:0]   sum_acc_q, sum_acc_d;
  logic [LIT_W-1:0]   lit_count_q, lit_count_d;
  logic [SUM_W-1:0]   color_sum_q, color_sum_d;
  logic               err_q, err_d;

  rgb444_t            rgb_in;
  logic               active;
  logic [COORD_W-1:0] sy_inc;
  logic               line_err;
  logic               hs_err;
  logic               frame_err;
  logic               any_err;

  always_comb begin
    rgb_in = '{r: r_i, g: g_i, b: b_i};
    active = (state_q != ST_SEARCH);

    pixel_valid_d = de_lvl;
    rgb_d         = rgb_in;

    sx_d = sx_q;
    if (de_rise) begin
      sx_d = '0;
    end else if (de_lvl) begin
      sx_d = (sx_q == '1) ? sx_q : sx_q + COORD_W'(1);
    end

    // A line that ends in the same cycle as the vsync edge still counts toward the frame.
    sy_inc = sy_q;
    if (de_fall) begin
      sy_inc = (sy_q == '1) ? sy_q : sy_q + COORD_W'(1);
    end
    sy_d = vs_rise ? '0 : sy_inc;

    h_cnt_d  = hs_rise ? HCNT_W'(1) : ((h_cnt_q == '1) ? h_cnt_q : h_cnt_q + HCNT_W'(1));
    h_seen_d = h_seen_q | hs_rise;

    line_err  = active && ((de_fall && (sx_q != COORD_W'(h_active_p - 1))) || (vs_rise && de_lvl));
    hs_err    = active && hs_rise && h_seen_q && (h_cnt_q != HCNT_W'(h_total_p));
    frame_err = active && vs_rise && (sy_inc != COORD_W'(v_active_p));
    any_err   = line_err | hs_err | frame_err;

    state_d     = state_q;
    align_err_d = align_err_q;
    err_d       = err_q | any_err;
    unique case (state_q)
      ST_SEARCH: begin
        if (vs_rise) begin
          state_d     = ST_ALIGN;
          align_err_d = 1'b0;
        end
      end
      ST_ALIGN: begin
        if (any_err) begin
          align_err_d = 1'b1;
        end
        if (vs_rise) begin
          state_d = (align_err_q || any_err) ? ST_SEARCH : ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          state_d = ST_SEARCH;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
    locked_d = (state_d == ST_LOCKED);

    lit_acc_d = lit_acc_q;
    sum_acc_d = sum_acc_q;
    if (active && de_lvl) begin
      if (rgb_in != '0) begin
        lit_acc_d = (lit_acc_q == '1) ? lit_acc_q : lit_acc_q + LIT_W'(1);
      end
      sum_acc_d = sum_acc_q + SUM_W'(rgb_sum(rgb_in));
    end

    // The closing edge publishes the previous frame and starts a fresh one.
    frame_done_d = vs_rise && active;
    lit_count_d  = lit_count_q;
    color_sum_d  = color_sum_q;
    if (frame_done_d) begin
      lit_count_d = lit_acc_q;
      color_sum_d = sum_acc_q;
    end
    if (vs_rise) begin
      lit_acc_d = '0;
      sum_acc_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_SEARCH;
      align_err_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
      sx_q          <= '0;
      sy_q          <= '0;
      rgb_q         <= '0;
      h_cnt_q       <= '0;
      h_seen_q      <= 1'b0;
      locked_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      lit_acc_q     <= '0;
      sum_acc_q     <= '0;
      lit_count_q   <= '0;
      color_sum_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      align_err_q   <= align_err_d;
      pixel_valid_q <= pixel_valid_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      rgb_q         <= rgb_d;
      h_cnt_q       <= h_cnt_d;
      h_seen_q      <= h_seen_d;
      locked_q      <= locked_d;
      frame_done_q  <= frame_done_d;
      lit_acc_q     <= lit_acc_d;
      sum_acc_q     <= sum_acc_d;
      lit_count_q   <= lit_count_d;
      color_sum_q   <= color_sum_d;
      err_q         <= err_d;
    end
  end

  assign pixel_valid_o = pixel_valid_q;
  assign sx_o          = sx_q;
  assign sy_o          = sy_q;
  assign rgb_o         = rgb_q;
  assign locked_o      = locked_q;
  assign frame_done_o  = frame_done_q;
  assign lit_count_o   = lit_count_q;
  assign color_sum_o   = color_sum_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_dvi_stream_monitor.sv
// Directed bench for dvi_stream_monitor using a scaled-down 16x24 raster (24 clocks/line, 28 lines/frame).
module tb_dvi_stream_monitor;

  localparam int H_ACT = 16;
  localparam int V_ACT = 24;
  localparam int H_TOT = 24;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic hsync_lo = 1'b1;
  logic vsync_lo = 1'b1;
  logic hsync_hi = 1'b0;
  logic vsync_hi = 1'b0;
  logic de_i = 1'b0;
  logic [3:0] r_i = 4'd0;
  logic [3:0] g_i = 4'd0;
  logic [3:0] b_i = 4'd0;

  logic        pixel_valid_o;
  logic [9:0]  sx_o;
  logic [9:0]  sy_o;
  logic [11:0] rgb_o;
  logic        locked_o;
  logic        frame_done_o;
  logic [18:0] lit_count_o;
  logic [15:0] color_sum_o;
  logic        err_o;

  logic        hi_pixel_valid;
  logic [9:0]  hi_sx;
  logic [9:0]  hi_sy;
  logic [11:0] hi_rgb;
  logic        hi_locked;
  logic        hi_frame_done;
  logic [18:0] hi_lit_count;
  logic [15:0] hi_color_sum;
  logic        hi_err;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic box_seen = 1'b0;
  logic [9:0] box_sx = '0;
  logic [9:0] box_sy = '0;

  always #5 clk = ~clk;

  dvi_stream_monitor #(
    .h_active_p        (H_ACT),
    .v_active_p        (V_ACT),
    .h_total_p         (H_TOT),
    .sync_active_low_p (1)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .hsync_i       (hsync_lo),
    .vsync_i       (vsync_lo),
    .de_i          (de_i),
    .r_i           (r_i),
    .g_i           (g_i),
    .b_i           (b_i),
    .pixel_valid_o (pixel_valid_o),
    .sx_o          (sx_o),
    .sy_o          (sy_o),
    .rgb_o         (rgb_o),
    .locked_o      (locked_o),
    .frame_done_o  (frame_done_o),
    .lit_count_o   (lit_count_o),
    .color_sum_o   (color_sum_o),
    .err_o         (err_o)
  );

  dvi_stream_monitor #(
    .h_active_p        (H_ACT),
    .v_active_p        (V_ACT),
    .h_total_p         (H_TOT),
    .sync_active_low_p (0)
  ) dut_hi (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .hsync_i       (hsync_hi),
    .vsync_i       (vsync_hi),
    .de_i          (de_i),
    .r_i           (r_i),
    .g_i           (g_i),
    .b_i           (b_i),
    .pixel_valid_o (hi_pixel_valid),
    .sx_o          (hi_sx),
    .sy_o          (hi_sy),
    .rgb_o         (hi_rgb),
    .locked_o      (hi_locked),
    .frame_done_o  (hi_frame_done),
    .lit_count_o   (hi_lit_count),
    .color_sum_o   (hi_color_sum),
    .err_o         (hi_err)
  );

  always @(negedge clk) begin
    if (frame_done_o) done_cnt <= done_cnt + 1;
    if (pixel_valid_o && rgb_o == 12'hFFF && !box_seen) begin
      box_seen <= 1'b1;
      box_sx   <= sx_o;
      box_sy   <= sy_o;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic hs_a, input logic vs_a, input logic de, input logic [11:0] px);
    @(negedge clk);
    hsync_lo = ~hs_a;
    vsync_lo = ~vs_a;
    hsync_hi = hs_a;
    vsync_hi = vs_a;
    de_i     = de;
    {r_i, g_i, b_i} = de ? px : 12'h000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    hsync_lo = 1'b1; vsync_lo = 1'b1; hsync_hi = 1'b0; vsync_hi = 1'b0;
    de_i = 1'b0; {r_i, g_i, b_i} = 12'h000;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
  endtask

  // act_lines active lines, then 1 front-porch, 2 vsync and 1 back-porch line.
  task automatic run_frame(input int act_lines, input int short_line, input int long_line,
                           input logic [11:0] colour, input bit box);
    for (int ln = 0; ln < act_lines + 4; ln++) begin
      int len;
      int de_len;
      len    = (ln == long_line) ? H_TOT + 1 : H_TOT;
      de_len = (ln == short_line) ? H_ACT - 1 : H_ACT;
      for (int c = 0; c < len; c++) begin
        logic [11:0] px;
        px = colour;
        if (box) px = (ln >= 20 && ln < 22 && c >= 10 && c < 14) ? 12'hFFF : 12'h000;
        drive(c >= 18 && c < 21, ln >= act_lines + 1 && ln < act_lines + 3,
              ln < act_lines && c < de_len, px);
      end
    end
  endtask

  initial begin
    do_reset();
    check("rst_valid", pixel_valid_o, 0);
    check("rst_sx", sx_o, 0);
    check("rst_sy", sy_o, 0);
    check("rst_rgb", rgb_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_lit", lit_count_o, 0);
    check("rst_sum", color_sum_o, 0);
    check("rst_err", err_o, 0);

    run_frame(V_ACT, -1, -1, 12'h111, 0);
    check("f1_locked", locked_o, 0);
    check("f1_done", done_cnt, 0);
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    check("f2_locked", locked_o, 1);
    check("f2_hi_locked", hi_locked, 1);
    check("f2_done", done_cnt, 1);
    check("f2_lit", lit_count_o, 384);
    check("f2_sum", color_sum_o, 1152);
    check("f2_hi_lit", hi_lit_count, 384);
    check("f2_err", err_o, 0);

    run_frame(V_ACT, -1, -1, 12'h000, 1);
    check("box_lit", lit_count_o, 8);
    check("box_sum", color_sum_o, 360);
    check("box_seen", box_seen, 1);
    check("box_sx", box_sx, 10);
    check("box_sy", box_sy, 20);
    check("box_done", done_cnt, 2);

    run_frame(V_ACT, 5, -1, 12'h111, 0);
    check("short_err", err_o, 1);
    check("short_locked", locked_o, 0);
    check("short_nodone", done_cnt, 2);
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    check("short_relock", locked_o, 1);
    check("short_relock_done", done_cnt, 3);
    check("short_err_sticky", err_o, 1);

    do_reset();
    check("rst2_err", err_o, 0);
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    check("v_pre_locked", locked_o, 1);
    check("v_pre_done", done_cnt, 4);
    run_frame(V_ACT - 1, -1, -1, 12'h111, 0);
    check("v_err", err_o, 1);
    check("v_locked", locked_o, 0);
    check("v_done", done_cnt, 5);
    check("v_lit", lit_count_o, 368);
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    check("v_nodone", done_cnt, 5);
    check("v_still_unlocked", locked_o, 0);

    do_reset();
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    check("h_pre_locked", locked_o, 1);
    check("h_pre_err", err_o, 0);
    run_frame(V_ACT, -1, 3, 12'h111, 0);
    check("h_err", err_o, 1);
    check("h_locked", locked_o, 0);
    check("h_hi_err", hi_err, 1);
    check("h_nodone", done_cnt, 6);

    for (int c = 0; c < 6; c++) drive(1'b0, 1'b0, 1'b1, 12'h111);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_valid", pixel_valid_o, 0);
    check("mrst_sx", sx_o, 0);
    check("mrst_rgb", rgb_o, 0);
    check("mrst_lit", lit_count_o, 0);
    check("mrst_sum", color_sum_o, 0);
    check("mrst_err", err_o, 0);
    check("mrst_hi_err", hi_err, 0);
    reset_i = 1'b0;
    for (int c = 7; c < H_TOT; c++) drive(c >= 18 && c < 21, 1'b0, c < H_ACT, 12'h111);
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    check("mrst_f1_locked", locked_o, 0);
    run_frame(V_ACT, -1, -1, 12'h111, 0);
    check("mrst_relock", locked_o, 1);
    check("mrst_hi_relock", hi_locked, 1);
    check("mrst_lit2", lit_count_o, 384);
    check("mrst_done", done_cnt, 7);
    check("mrst_err2", err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
